// File: rtl/fmul_pkg.sv
// Shared definitions for the single-precision multiplier back end.
package fmul_pkg;

  // Rounding-mode encodings as carried on the rm bus.
  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RDN = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RTZ = 2'b11;

  localparam logic [7:0]  EXP_INF    = 8'hFF;
  localparam logic [30:0] MAX_FINITE = 31'h7F7FFFFF;

  // Bundle field widths.
  localparam int unsigned ZW   = 40;
  localparam int unsigned Z8W  = 8;
  localparam int unsigned EXPW = 10;

  // Fields that ride along the pipeline untouched until packing.
  typedef struct packed {
    logic        sign;
    logic [1:0]  rm;
    logic        is_nan;
    logic        is_inf;
    logic [22:0] nan_frac;
  } ctl_t;

  // Leading-zero count of a 47-bit vector; 47 when the vector is zero.
  function automatic logic [5:0] lzc47(input logic [46:0] v);
    logic [5:0] n;
    n = 6'd47;
    // Ascending scan: the last hit is the most significant set bit.
    for (int i = 0; i < 47; i++) begin
      if (v[i]) n = 6'(46 - i);
    end
    return n;
  endfunction

endpackage

// File: rtl/fmul_norm.sv
// Combinational normalizer: aligns the 48-bit product into a 24-bit
// significand with guard/sticky and derives the pre-rounding exponent.
module fmul_norm
  import fmul_pkg::*;
(
  input  logic [47:0]     p,
  input  logic [EXPW-1:0] exp10,
  output logic [23:0]     sig24,
  output logic            guard,
  output logic            sticky,
  output logic [EXPW-1:0] e10
);

  logic [46:0] x;
  logic [72:0] wide;
  logic [10:0] rsh_full;
  logic [4:0]  rsh;
  logic [5:0]  lz;
  logic [5:0]  lsh;
  logic [9:0]  lim;
  logic [46:0] y;

  // Shift amounts for the denormal right shift and the left renormalization.
  always_comb begin
    x        = p[46:0];
    lz       = lzc47(x);
    // Only meaningful when exp10 <= 0, where it lies in 1..513.
    rsh_full = 11'd1 - {exp10[9], exp10};
    rsh      = (rsh_full > 11'd26) ? 5'd26 : rsh_full[4:0];
    // 26 spare low bits so a saturated shift loses nothing before sticky.
    wide     = {x, 26'b0} >> rsh;
    lim      = exp10 - 10'd1;
    lsh      = ({4'b0, lz} < lim) ? lz : lim[5:0];
    y        = x << lsh;
  end

  // Case selection, evaluated in priority order.
  always_comb begin
    sig24  = x[46:23];
    guard  = x[22];
    sticky = |x[21:0];
    e10    = exp10;
    if (p[47]) begin
      sig24  = p[47:24];
      guard  = p[23];
      sticky = |p[22:0];
      e10    = exp10 + 10'd1;
    end else if ($signed(exp10) <= 10'sd0) begin
      sig24  = wide[72:49];
      guard  = wide[48];
      sticky = |wide[47:0];
      e10    = '0;
    end else if (!p[46]) begin
      sig24  = y[46:23];
      guard  = y[22];
      sticky = |y[21:0];
      // Exponent floor reached before the hidden bit: result is denormal.
      e10    = y[46] ? (exp10 - {4'b0, lsh}) : '0;
    end
  end

endmodule

// File: rtl/fmul_norm_round.sv
// Multiplier back end: carry-propagate add, normalize, round and pack,
// as a three-stage valid/ready pipeline.
module fmul_norm_round
  import fmul_pkg::*;
(
  input  logic             clk,
  input  logic             clrn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       rm,
  input  logic             sign,
  input  logic [EXPW-1:0]  exp10,
  input  logic             s_is_nan,
  input  logic             s_is_inf,
  input  logic [22:0]      inf_nan_frac,
  input  logic [ZW-1:0]    z_sum,
  input  logic [ZW-1:0]    z_carry,
  input  logic [Z8W-1:0]   z8,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      s
);

  logic adv2, adv3;
  logic v1_q, v2_q, v3_q;

  logic [ZW-1:0]   z_cpa;
  logic [47:0]     p_d;
  ctl_t            ctl_in;

  logic [47:0]     p1_q;
  logic [EXPW-1:0] exp1_q;
  ctl_t            ctl1_q;

  logic [23:0]     sig_n;
  logic            guard_n, sticky_n;
  logic [EXPW-1:0] e_n;

  logic [23:0]     sig2_q;
  logic            guard2_q, sticky2_q;
  logic [EXPW-1:0] e2_q;
  ctl_t            ctl2_q;

  logic            inc, away, ovf;
  logic [24:0]     sum25;
  logic [EXPW-1:0] e_r;
  logic [31:0]     s_d, s_q;

  // Ready chain: a stage may take new data when empty or when it empties this cycle.
  assign adv3      = ~v3_q | out_ready;
  assign adv2      = ~v2_q | adv3;
  assign in_ready  = ~v1_q | adv2;
  assign out_valid = v3_q;
  assign s         = s_q;

  // Carry-propagate add of the carry-save product and bundle field gathering.
  always_comb begin
    z_cpa           = z_sum + z_carry;
    p_d             = {z_cpa, z8};
    ctl_in          = '0;
    ctl_in.sign     = sign;
    ctl_in.rm       = rm;
    ctl_in.is_nan   = s_is_nan;
    ctl_in.is_inf   = s_is_inf;
    ctl_in.nan_frac = inf_nan_frac;
  end

  // Stage 1: register the full product and control fields.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      v1_q   <= 1'b0;
      p1_q   <= '0;
      exp1_q <= '0;
      ctl1_q <= '0;
    end else if (in_ready) begin
      v1_q <= in_valid;
      if (in_valid) begin
        p1_q   <= p_d;
        exp1_q <= exp10;
        ctl1_q <= ctl_in;
      end
    end
  end

  fmul_norm u_norm (
    .p      (p1_q),
    .exp10  (exp1_q),
    .sig24  (sig_n),
    .guard  (guard_n),
    .sticky (sticky_n),
    .e10    (e_n)
  );

  // Stage 2: register the normalized significand and exponent.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      v2_q      <= 1'b0;
      sig2_q    <= '0;
      guard2_q  <= 1'b0;
      sticky2_q <= 1'b0;
      e2_q      <= '0;
      ctl2_q    <= '0;
    end else if (adv2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        sig2_q    <= sig_n;
        guard2_q  <= guard_n;
        sticky2_q <= sticky_n;
        e2_q      <= e_n;
        ctl2_q    <= ctl1_q;
      end
    end
  end

  // Rounding, overflow saturation, special-value override and packing.
  always_comb begin
    inc = 1'b0;
    unique case (ctl2_q.rm)
      RM_RNE: inc = guard2_q & (sticky2_q | sig2_q[0]);
      RM_RDN: inc = ctl2_q.sign & (guard2_q | sticky2_q);
      RM_RUP: inc = ~ctl2_q.sign & (guard2_q | sticky2_q);
      RM_RTZ: inc = 1'b0;
    endcase
    away = (ctl2_q.rm == RM_RNE) ||
           ((ctl2_q.rm == RM_RDN) && ctl2_q.sign) ||
           ((ctl2_q.rm == RM_RUP) && !ctl2_q.sign);
    sum25 = {1'b0, sig2_q} + {24'b0, inc};
    e_r   = e2_q;
    if (sum25[24]) begin
      e_r = e2_q + 10'd1;
    end else if ((e2_q == '0) && sum25[23]) begin
      e_r = 10'd1;
    end
    ovf = $signed(e_r) >= 10'sd255;
    if (ctl2_q.is_nan) begin
      s_d = {ctl2_q.sign, EXP_INF, ctl2_q.nan_frac};
    end else if (ctl2_q.is_inf) begin
      s_d = {ctl2_q.sign, EXP_INF, 23'b0};
    end else if (ovf) begin
      s_d = away ? {ctl2_q.sign, EXP_INF, 23'b0} : {ctl2_q.sign, MAX_FINITE};
    end else begin
      // On significand carry-out sum25[22:0] is already zero.
      s_d = {ctl2_q.sign, e_r[7:0], sum25[22:0]};
    end
  end

  // Stage 3: output register, held while downstream stalls.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      v3_q <= 1'b0;
      s_q  <= '0;
    end else if (adv3) begin
      v3_q <= v2_q;
      if (v2_q) s_q <= s_d;
    end
  end

endmodule

// File: tb/tb_fmul_norm_round.sv
// Directed bench for the multiplier back end.
module tb_fmul_norm_round;

  logic        clk;
  logic        clrn;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  rm;
  logic        sign;
  logic [9:0]  exp10;
  logic        s_is_nan;
  logic        s_is_inf;
  logic [22:0] inf_nan_frac;
  logic [39:0] z_sum;
  logic [39:0] z_carry;
  logic [7:0]  z8;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;

  int errors;
  int checks;

  fmul_norm_round dut (
    .clk          (clk),
    .clrn         (clrn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .rm           (rm),
    .sign         (sign),
    .exp10        (exp10),
    .s_is_nan     (s_is_nan),
    .s_is_inf     (s_is_inf),
    .inf_nan_frac (inf_nan_frac),
    .z_sum        (z_sum),
    .z_carry      (z_carry),
    .z8           (z8),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .s            (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Carry-save split of the product: sum = P[47:8]-5, carry = 5.
  task automatic drive_bundle(input logic [47:0] p, input logic [9:0] e, input logic sg,
                              input logic [1:0] r, input logic nan, input logic inf,
                              input logic [22:0] fr);
    z_sum        = p[47:8] - 40'd5;
    z_carry      = 40'd5;
    z8           = p[7:0];
    exp10        = e;
    sign         = sg;
    rm           = r;
    s_is_nan     = nan;
    s_is_inf     = inf;
    inf_nan_frac = fr;
  endtask

  // Stream vectors with hand-computed results.
  task automatic set_vec(input int k, output logic [31:0] want);
    case (k)
      0: begin drive_bundle(48'h600000000000, 10'd128, 1'b0, 2'b00, 1'b0, 1'b0, 23'h0);
               want = 32'h40400000; end
      1: begin drive_bundle(48'h600000C00000, 10'd127, 1'b0, 2'b00, 1'b0, 1'b0, 23'h0);
               want = 32'h3FC00002; end
      2: begin drive_bundle(48'h400000000000, 10'd0, 1'b0, 2'b00, 1'b0, 1'b0, 23'h0);
               want = 32'h00400000; end
      default: begin drive_bundle(48'h100000000000, 10'd127, 1'b0, 2'b00, 1'b0, 1'b0, 23'h0);
               want = 32'h3E800000; end
    endcase
  endtask

  // One isolated transaction; lat counts edges after acceptance until out_valid.
  task automatic run_one(input logic [47:0] p, input logic [9:0] e, input logic sg,
                         input logic [1:0] r, input logic nan, input logic inf,
                         input logic [22:0] fr, output logic [31:0] res, output int lat);
    @(negedge clk);
    drive_bundle(p, e, sg, r, nan, inf, fr);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (out_valid) begin
      res = s;
    end else begin
      res = 'x;
      lat = -1;
    end
  endtask

  task automatic test_reset();
    clrn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive_bundle(48'h0, 10'd0, 1'b0, 2'b00, 1'b0, 1'b0, 23'h0);
    #12;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (s !== 32'h0) begin
      errors++; $display("FAIL reset_s: got %h want 00000000", s);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] res;
    int lat;
    run_one(48'h600000000000, 10'd128, 1'b0, 2'b00, 1'b0, 1'b0, 23'h0, res, lat);
    checks++;
    if (res !== 32'h40400000) begin
      errors++; $display("FAIL basic_1p5x2: got %h want 40400000", res);
    end
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL basic_latency: got %0d want 2", lat);
    end
    run_one(48'h100000000000, 10'd127, 1'b0, 2'b00, 1'b0, 1'b0, 23'h0, res, lat);
    checks++;
    if (res !== 32'h3E800000) begin
      errors++; $display("FAIL left_shift: got %h want 3E800000", res);
    end
    run_one(48'h000000000000, 10'd100, 1'b1, 2'b00, 1'b0, 1'b0, 23'h0, res, lat);
    checks++;
    if (res !== 32'h80000000) begin
      errors++; $display("FAIL zero_product: got %h want 80000000", res);
    end
  endtask

  task automatic test_rounding();
    logic [31:0] res, want;
    logic [47:0] p;
    logic [9:0]  e;
    logic        sg;
    logic [1:0]  r;
    int lat;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin p = 48'h600000C00000; e = 10'd127; sg = 1'b0; r = 2'b00; want = 32'h3FC00002; end
        1: begin p = 48'h600000C00000; e = 10'd127; sg = 1'b0; r = 2'b11; want = 32'h3FC00001; end
        2: begin p = 48'h600000C00000; e = 10'd127; sg = 1'b1; r = 2'b01; want = 32'hBFC00002; end
        3: begin p = 48'h600000C00000; e = 10'd127; sg = 1'b1; r = 2'b10; want = 32'hBFC00001; end
        default: begin p = 48'h7FFFFFC00000; e = 10'd127; sg = 1'b0; r = 2'b00;
                       want = 32'h40000000; end
      endcase
      run_one(p, e, sg, r, 1'b0, 1'b0, 23'h0, res, lat);
      checks++;
      if (res !== want) begin
        errors++; $display("FAIL round_%0d: got %h want %h", i, res, want);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] res, want;
    logic        sg;
    logic [1:0]  r;
    int lat;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin sg = 1'b0; r = 2'b00; want = 32'h7F800000; end
        1: begin sg = 1'b0; r = 2'b11; want = 32'h7F7FFFFF; end
        2: begin sg = 1'b1; r = 2'b01; want = 32'hFF800000; end
        default: begin sg = 1'b1; r = 2'b10; want = 32'hFF7FFFFF; end
      endcase
      run_one(48'h800000000000, 10'd254, sg, r, 1'b0, 1'b0, 23'h0, res, lat);
      checks++;
      if (res !== want) begin
        errors++; $display("FAIL overflow_%0d: got %h want %h", i, res, want);
      end
    end
  endtask

  task automatic test_denormal();
    logic [31:0] res;
    int lat;
    run_one(48'h400000000000, 10'd0, 1'b0, 2'b00, 1'b0, 1'b0, 23'h0, res, lat);
    checks++;
    if (res !== 32'h00400000) begin
      errors++; $display("FAIL denorm_half: got %h want 00400000", res);
    end
    run_one(48'h7FFFFF800000, 10'd0, 1'b0, 2'b00, 1'b0, 1'b0, 23'h0, res, lat);
    checks++;
    if (res !== 32'h00800000) begin
      errors++; $display("FAIL denorm_to_hidden: got %h want 00800000", res);
    end
    // exp10 = -30: shift saturates at 26 and the lone set bit lands in sticky.
    run_one(48'h400000000000, 10'h3E2, 1'b0, 2'b10, 1'b0, 1'b0, 23'h0, res, lat);
    checks++;
    if (res !== 32'h00000001) begin
      errors++; $display("FAIL denorm_sat_rup: got %h want 00000001", res);
    end
    run_one(48'h400000000000, 10'h3E2, 1'b0, 2'b00, 1'b0, 1'b0, 23'h0, res, lat);
    checks++;
    if (res !== 32'h00000000) begin
      errors++; $display("FAIL denorm_sat_rne: got %h want 00000000", res);
    end
  endtask

  task automatic test_specials();
    logic [31:0] res;
    int lat;
    run_one(48'h600000000000, 10'd128, 1'b0, 2'b00, 1'b1, 1'b0, 23'h400000, res, lat);
    checks++;
    if (res !== 32'h7FC00000) begin
      errors++; $display("FAIL nan: got %h want 7FC00000", res);
    end
    run_one(48'h600000000000, 10'd128, 1'b1, 2'b00, 1'b0, 1'b1, 23'h0, res, lat);
    checks++;
    if (res !== 32'hFF800000) begin
      errors++; $display("FAIL inf: got %h want FF800000", res);
    end
    run_one(48'h600000000000, 10'd128, 1'b1, 2'b11, 1'b1, 1'b1, 23'h000001, res, lat);
    checks++;
    if (res !== 32'hFF800001) begin
      errors++; $display("FAIL nan_over_inf: got %h want FF800001", res);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want [4];
    logic [31:0] got [8];
    logic [31:0] w;
    int accepted, n, first_k, last_k, stalls;
    // Fill under backpressure.
    @(negedge clk);
    out_ready = 1'b0;
    accepted  = 0;
    set_vec(0, w);
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (in_ready) accepted++;
      @(negedge clk);
      set_vec((accepted > 3) ? 3 : accepted, w);
    end
    in_valid = 1'b0;
    checks++;
    if (accepted != 3) begin
      errors++; $display("FAIL bp_accept_count: got %0d want 3", accepted);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b1 || s !== 32'h40400000) begin
      errors++; $display("FAIL bp_head: got v=%b s=%h want v=1 s=40400000", out_valid, s);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (s !== 32'h40400000) begin
      errors++; $display("FAIL bp_hold: got %h want 40400000", s);
    end
    // Drain.
    out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin
        got[n] = s;
        n++;
      end
      @(negedge clk);
    end
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL drain_count: got %0d want 3", n);
    end
    for (int i = 0; i < 3; i++) begin
      set_vec(i, want[i]);
      checks++;
      if (i < n && got[i] !== want[i]) begin
        errors++; $display("FAIL drain_%0d: got %h want %h", i, got[i], want[i]);
      end
    end
    // Full throughput with out_ready held high.
    n = 0; first_k = -1; last_k = -1; stalls = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) begin
        if (n < 8) got[n] = s;
        n++;
        if (first_k < 0) first_k = k;
        last_k = k;
      end
      if (k < 4) begin
        set_vec(k, want[k]);
        in_valid = 1'b1;
        if (!in_ready) stalls++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (stalls != 0 || n != 4 || first_k != 3 || last_k != 6) begin
      errors++;
      $display("FAIL throughput: got stalls=%0d n=%0d first=%0d last=%0d want 0 4 3 6",
               stalls, n, first_k, last_k);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i < n && got[i] !== want[i]) begin
        errors++; $display("FAIL stream_%0d: got %h want %h", i, got[i], want[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w, res;
    int lat, seen;
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_vec(k, w);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_prefill: got %b want 1", out_valid);
    end
    clrn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || s !== 32'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_clear: got v=%b s=%h rdy=%b want v=0 s=00000000 rdy=1",
               out_valid, s, in_ready);
    end
    @(negedge clk);
    clrn      = 1'b1;
    out_ready = 1'b1;
    seen      = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midrst_stale: got %0d outputs want 0", seen);
    end
    run_one(48'h100000000000, 10'd127, 1'b0, 2'b00, 1'b0, 1'b0, 23'h0, res, lat);
    checks++;
    if (res !== 32'h3E800000) begin
      errors++; $display("FAIL midrst_recover: got %h want 3E800000", res);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_rounding();
    test_overflow();
    test_denormal();
    test_specials();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
